adc_seq_ctrl: RTL and testbench
===============================

Name: adc_seq_ctrl

Overview:
Parametrised multi-channel ADC sequencer. It replaces single-shot use of the analog-digital handshake (adc_convert / adc_ready / adc_q). On a start request it sweeps all enabled channels in ascending order, optionally averaging 2^k samples per channel, and holds one result per channel for the register/I2C layer. It sits between the register block and the analog ADC macro, with a channel mux select and a conversion-timeout guard.

Parameters:
NUM_CH, 4, number of analog input channels (1..16)
DATA_W, 8, ADC result width
AVG_MAX_LOG2, 3, maximum averaging exponent (up to 8 samples/channel)
TIMEOUT_CYC, 255, cycles allowed between adc_convert and adc_ready before abort

Ports:
clk  in  1  chip clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle sweep request; ignored while busy
continuous  in  1  1 = restart sweep automatically after each sweep
ch_enable  in  NUM_CH  per-channel enable, bit i = channel i
avg_log2  in  $clog2(AVG_MAX_LOG2+1)  averaging exponent k; values above AVG_MAX_LOG2 clamp to AVG_MAX_LOG2
adc_convert  out  1  one-cycle conversion request to ADC
adc_sel  out  $clog2(NUM_CH)  analog mux channel select
adc_ready  in  1  one-cycle pulse: adc_q valid
adc_q  in  DATA_W  ADC conversion result
result  out  NUM_CH*DATA_W  per-channel averaged result, channel i at [i*DATA_W +: DATA_W]
result_valid  out  NUM_CH  bit i set when result i written since last start
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at end of each sweep (normal or aborted)
timeout_err  out  1  sticky: sweep aborted on timeout; cleared by next accepted start

Behaviour:
- Reset values: adc_convert=0, adc_sel=0, result=0, result_valid=0, busy=0, done=0, timeout_err=0. FSM goes to IDLE and the accumulator clears. Reset mid-conversion discards the in-flight sample; a later adc_ready is ignored in IDLE.
- Config capture: ch_enable, avg_log2 and continuous are latched on start acceptance and re-latched at each continuous restart. Changes during a sweep have no effect on that sweep.
- FSM states: IDLE, SELECT, CONVERT, WAIT, STORE.
- IDLE: start=1 -> latch config, clear result_valid and timeout_err, busy=1. If ch_enable==0, go to IDLE with done=1 on the next cycle and issue no conversion. Otherwise, go to SELECT with adc_sel = lowest enabled channel.
- SELECT: one settle cycle for the mux, then CONVERT.
- CONVERT: adc_convert=1 for exactly one cycle, timeout counter cleared, then WAIT. Latency from start to adc_convert is 2 cycles (start@T0, SELECT@T1, convert@T2).
- WAIT: count cycles.
  - If adc_ready=1: acc += adc_q zero-extended to DATA_W+AVG_MAX_LOG2 bits, sample count +1. If count reaches 2^k, go to STORE; else go to CONVERT (same channel, no extra settle).
  - If the counter reaches TIMEOUT_CYC with no adc_ready: set timeout_err=1, pulse done, busy=0, go to IDLE. Leave result and result_valid of the current channel unchanged. Continuous mode stops.
- adc_ready outside WAIT is ignored.
- STORE: result[ch] = acc >> k (truncating), result_valid[ch]=1, clear acc.
  - Next enabled higher channel -> SELECT.
  - No higher channel: pulse done. If the latched continuous=1, re-latch config and go to SELECT with the lowest enabled channel (busy stays 1). If continuous=0, busy=0 and go to IDLE.
- Deasserting continuous mid-sweep ends operation after the current sweep completes.
- start while busy is ignored and is not queued.
- Accumulator cannot overflow: max sum (2^DATA_W - 1) * 2^AVG_MAX_LOG2 fits in DATA_W+AVG_MAX_LOG2 bits.
- done and adc_convert are never high for more than one consecutive cycle.

Decomposition:
- Package adc_seq_pkg: state enum (IDLE, SELECT, CONVERT, WAIT, STORE), localparams CH_W=$clog2(NUM_CH), ACC_W=DATA_W+AVG_MAX_LOG2, CNT_W=$clog2(TIMEOUT_CYC+1).
- One sub-module, adc_seq_next_ch: combinational priority encoder returning the next enabled channel index above the current one, plus a "none" flag. It is also reused, with current = -1, to find the first channel.
- Result registers, accumulator and FSM live in the top module.

Test Plan:
- Single sweep, NUM_CH=4, ch_enable=4'b1011, k=0, ADC model returns 8'h10+ch with adc_ready 5 cycles after convert -> conversions on adc_sel 0,1,3 only; result = {8'h13,8'h00,8'h11,8'h10}; result_valid=4'b1011; exactly one done pulse; busy low after done.
- Averaging, ch_enable=4'b0001, k=2, samples 10, 11, 12, 14 -> 4 adc_convert pulses, result[0]=11 (47>>2); avg_log2=7 behaves as k=3 (8 conversions).
- Timeout: ADC model never asserts adc_ready on channel 2, ch_enable=4'b0111 -> channels 0 and 1 valid; exactly TIMEOUT_CYC cycles after the convert, timeout_err=1 and done pulses; result_valid=4'b0011; next start clears timeout_err.
- Continuous: continuous=1, ch_enable=4'b0011 -> repeated sweeps with one done per sweep and busy held high; drop continuous mid-sweep -> that sweep finishes, then busy=0. start pulses while busy produce no extra conversions.
- Edge cases: ch_enable=0 with start -> done one cycle later, no adc_convert. A reset pulse during WAIT, followed by a late adc_ready -> all outputs return to reset values and the late ready is ignored. A spurious adc_ready in IDLE leaves result unchanged.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the multi-channel ADC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_seq_pkg;

  // Default sizing of the sequencer. The top module uses these as parameter defaults.
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_AVG_MAX_LOG2 = 3;
  localparam int DEF_TIMEOUT_CYC  = 255;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_STORE   = 3'd4
  } state_t;

  // Width needed to index n values, never below one bit. This keeps a
  // single-channel build from producing zero-width selects.
  function automatic int width_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Limit a requested averaging exponent to the largest supported one.
  function automatic int clamp_k(input int k, input int kmax);
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/adc_seq_next_ch.sv
// Finds the lowest enabled channel strictly above i_cur (or from channel 0 when i_first).
// Latency: purely combinational.
// Backpressure: none; o_none flags that no enabled channel remains.
module adc_seq_next_ch
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = width_of(DEF_NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  input  logic              i_first,
  output logic [CH_W-1:0]   o_next,
  output logic              o_none
);

  // Scan downwards so the lowest qualifying channel is the last (winning) assignment.
  always_comb begin
    o_next = '0;
    o_none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_next = CH_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Sweeps enabled ADC channels in ascending order, averaging 2^k samples each, and holds one result per channel.
// Latency: start -> adc_convert in 2 cycles; result/done appear the cycle after the last sample's STORE.
// Backpressure: start is ignored while a sweep runs (not queued); a stalled ADC aborts the sweep after TIMEOUT_CYC cycles.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int AVG_MAX_LOG2 = DEF_AVG_MAX_LOG2,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_start,
  input  logic                               i_continuous,
  input  logic [NUM_CH-1:0]                  i_ch_enable,
  input  logic [width_of(AVG_MAX_LOG2+1)-1:0] i_avg_log2,
  output logic                               o_adc_convert,
  output logic [width_of(NUM_CH)-1:0]        o_adc_sel,
  input  logic                               i_adc_ready,
  input  logic [DATA_W-1:0]                  i_adc_q,
  output logic [NUM_CH*DATA_W-1:0]           o_result,
  output logic [NUM_CH-1:0]                  o_result_valid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_timeout_err
);

  localparam int CH_W  = width_of(NUM_CH);
  localparam int K_W   = width_of(AVG_MAX_LOG2 + 1);
  localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
  localparam int CNT_W = width_of(TIMEOUT_CYC + 1);
  // Sample counter must hold 2^AVG_MAX_LOG2 itself.
  localparam int SMP_W = AVG_MAX_LOG2 + 1;

  state_t              r_state;
  state_t              w_next_state;

  // Configuration latched for the sweep in progress.
  logic [NUM_CH-1:0]   r_ch_en;
  logic [K_W-1:0]      r_k;
  logic                r_cont;

  // Datapath state.
  logic [CH_W-1:0]     r_sel;
  logic [ACC_W-1:0]    r_acc;
  logic [SMP_W-1:0]    r_nsamp;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_res [NUM_CH];
  logic [NUM_CH-1:0]   r_valid;
  logic                r_done;
  logic                r_timeout;

  logic [CH_W-1:0]     w_first_ch;
  logic                w_first_none;
  logic [CH_W-1:0]     w_next_ch;
  logic                w_next_none;
  logic                w_accept;
  logic                w_last_smp;
  logic                w_timeout_hit;
  logic                w_restart;
  logic [K_W-1:0]      w_k_in;
  logic [ACC_W-1:0]    w_avg;

  // First channel comes from the live enable mask: it is consulted exactly when the
  // configuration is being (re)latched, at start acceptance or continuous restart.
  adc_seq_next_ch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_first_ch (
    .i_mask  (i_ch_enable),
    .i_cur   ({CH_W{1'b0}}),
    .i_first (1'b1),
    .o_next  (w_first_ch),
    .o_none  (w_first_none)
  );

  // Next channel within the running sweep uses the latched mask.
  adc_seq_next_ch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next_ch (
    .i_mask  (r_ch_en),
    .i_cur   (r_sel),
    .i_first (1'b0),
    .o_next  (w_next_ch),
    .o_none  (w_next_none)
  );

  // The cycle carrying done still belongs to the finished sweep, so a start landing
  // on it is dropped; this keeps done from ever being high two cycles in a row.
  assign w_accept      = (r_state == ST_IDLE) && i_start && !r_done;
  assign w_k_in        = K_W'(clamp_k(int'(i_avg_log2), AVG_MAX_LOG2));
  assign w_last_smp    = ((r_nsamp + SMP_W'(1)) == (SMP_W'(1) << r_k));
  // r_cnt counts cycles since adc_convert, so done lands exactly TIMEOUT_CYC cycles after it.
  assign w_timeout_hit = !i_adc_ready && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // Restart needs continuous both latched for this sweep and still requested now,
  // so dropping continuous mid-sweep stops after the sweep in progress.
  assign w_restart     = r_cont && i_continuous;
  assign w_avg         = r_acc >> r_k;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_first_none) begin
          w_next_state = ST_SELECT;
        end
      end
      ST_SELECT: begin
        w_next_state = ST_CONVERT;
      end
      ST_CONVERT: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_adc_ready) begin
          w_next_state = w_last_smp ? ST_STORE : ST_CONVERT;
        end else if (w_timeout_hit) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STORE: begin
        if (!w_next_none) begin
          w_next_state = ST_SELECT;
        end else if (w_restart && !w_first_none) begin
          w_next_state = ST_SELECT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from state plus registered status.
  always_comb begin
    o_adc_convert  = (r_state == ST_CONVERT);
    o_busy         = (r_state != ST_IDLE);
    o_adc_sel      = r_sel;
    o_done         = r_done;
    o_timeout_err  = r_timeout;
    o_result_valid = r_valid;
    o_result       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_result[i*DATA_W +: DATA_W] = r_res[i];
    end
  end

  // Config latch, channel select, accumulator, timeout counter and done/error status.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ch_en   <= '0;
      r_k       <= '0;
      r_cont    <= 1'b0;
      r_sel     <= '0;
      r_acc     <= '0;
      r_nsamp   <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ch_en   <= i_ch_enable;
            r_k       <= w_k_in;
            r_cont    <= i_continuous;
            r_timeout <= 1'b0;
            r_acc     <= '0;
            r_nsamp   <= '0;
            r_sel     <= w_first_ch;
            // Empty mask: finish immediately without touching the ADC.
            r_done    <= w_first_none;
          end
        end
        ST_CONVERT: begin
          r_cnt <= CNT_W'(1);
        end
        ST_WAIT: begin
          if (i_adc_ready) begin
            r_acc   <= r_acc + ACC_W'(i_adc_q);
            r_nsamp <= r_nsamp + SMP_W'(1);
          end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STORE: begin
          r_acc   <= '0;
          r_nsamp <= '0;
          if (!w_next_none) begin
            r_sel <= w_next_ch;
          end else begin
            r_done <= 1'b1;
            if (w_restart) begin
              r_ch_en <= i_ch_enable;
              r_k     <= w_k_in;
              r_cont  <= i_continuous;
              if (!w_first_none) begin
                r_sel <= w_first_ch;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Per-channel result registers and their valid flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_res[i] <= '0;
      end
    end else if (w_accept) begin
      r_valid <= '0;
    end else if (r_state == ST_STORE) begin
      r_res[r_sel]   <= w_avg[DATA_W-1:0];
      r_valid[r_sel] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench: randomized sweeps against a per-sweep arithmetic model of the sequencer.
// Latency: checks the 2-cycle start->convert latency and the exact timeout distance.
// Backpressure: covers ignored starts while busy and ADC stall (timeout).
module tb_adc_seq_ctrl;

  localparam int NUM_CH       = 4;
  localparam int DATA_W       = 8;
  localparam int AVG_MAX_LOG2 = 3;
  localparam int TIMEOUT_CYC  = 255;
  localparam int K_W          = 2;
  localparam int CH_W         = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     continuous;
  logic [NUM_CH-1:0]        ch_enable;
  logic [K_W-1:0]           avg_log2;
  logic                     adc_convert;
  logic [CH_W-1:0]          adc_sel;
  logic                     adc_ready;
  logic [DATA_W-1:0]        adc_q;
  logic [NUM_CH*DATA_W-1:0] result;
  logic [NUM_CH-1:0]        result_valid;
  logic                     busy;
  logic                     done;
  logic                     timeout_err;

  always #5 clk = ~clk;

  adc_seq_ctrl #(
    .NUM_CH       (NUM_CH),
    .DATA_W       (DATA_W),
    .AVG_MAX_LOG2 (AVG_MAX_LOG2),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_continuous   (continuous),
    .i_ch_enable    (ch_enable),
    .i_avg_log2     (avg_log2),
    .o_adc_convert  (adc_convert),
    .o_adc_sel      (adc_sel),
    .i_adc_ready    (adc_ready),
    .i_adc_q        (adc_q),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC macro model and activity monitor.
  int         cyc = 0;
  int         cnt_down = 0;
  logic [7:0] pend = 8'h00;
  int         resp_mode = 0;    // 0: 0x10+ch, 1: preset queue, 2: random
  int         resp_delay = 5;   // 0 selects a random delay 1..6
  logic       drop_en = 1'b0;
  int         drop_ch = 0;
  logic       spur_req = 1'b0;
  int         conv_q[$];
  int         samp_q[$];
  int         pre_q[$];
  int         done_cnt = 0;
  int         viol = 0;
  int         last_conv_cyc = 0;
  logic       prev_done = 1'b0;
  logic       prev_conv = 1'b0;

  initial begin : adc_model
    adc_ready = 1'b0;
    adc_q     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      adc_ready = 1'b0;
      if (done === 1'b1) done_cnt++;
      if ((done === 1'b1 && prev_done) || (adc_convert === 1'b1 && prev_conv)) viol++;
      prev_done = (done === 1'b1);
      prev_conv = (adc_convert === 1'b1);
      if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0) begin
          adc_ready = 1'b1;
          adc_q     = pend;
        end
      end
      if (spur_req) begin
        adc_ready = 1'b1;
        adc_q     = 8'hAA;
        spur_req  = 1'b0;
      end
      if (adc_convert === 1'b1) begin
        conv_q.push_back(int'(adc_sel));
        last_conv_cyc = cyc;
        case (resp_mode)
          0:       pend = 8'h10 + 8'(adc_sel);
          1:       pend = (pre_q.size() > 0) ? 8'(pre_q.pop_front()) : 8'h00;
          default: pend = 8'($urandom);
        endcase
        samp_q.push_back(int'(pend));
        if (!(drop_en && int'(adc_sel) == drop_ch)) begin
          cnt_down = (resp_delay == 0) ? int'($urandom_range(1, 6)) : resp_delay;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: last value each result register should hold.
  logic [7:0] exp_res [NUM_CH];

  function automatic logic [31:0] pack_exp();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*8 +: 8] = exp_res[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_logs();
    conv_q.delete();
    samp_q.delete();
  endtask

  // One sweep: each enabled channel, ascending, gets 2^k conversions; result is sum >> k.
  task automatic model_check(input string tag, input logic [3:0] en, input int k);
    int ke, n, idx, seq_err, sum;
    ke = (k > AVG_MAX_LOG2) ? AVG_MAX_LOG2 : k;
    n = 1 << ke;
    idx = 0;
    seq_err = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (en[ch]) begin
        sum = 0;
        for (int s = 0; s < n; s++) begin
          if (idx < conv_q.size()) begin
            if (conv_q[idx] != ch) seq_err++;
            sum += samp_q[idx];
          end else begin
            seq_err++;
          end
          idx++;
        end
        exp_res[ch] = 8'(sum >> ke);
      end
    end
    check_eq({tag, "_nconv"}, 64'(conv_q.size()), 64'(idx));
    check_eq({tag, "_seq"}, 64'(seq_err), 64'(0));
    check_eq({tag, "_result"}, 64'(result), 64'(pack_exp()));
    check_eq({tag, "_valid"}, 64'(result_valid), 64'(en));
  endtask

  task automatic do_sweep(input string tag, input logic [3:0] en, input int k, input int mode, input int dly);
    int d0;
    bit ok;
    ch_enable  = en;
    avg_log2   = K_W'(k);
    continuous = 1'b0;
    resp_mode  = mode;
    resp_delay = dly;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    wait_done(3000, ok);
    check_eq({tag, "_done_seen"}, 64'(ok), 64'(1));
    tick();
    check_eq({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(1));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
    model_check(tag, en, k);
  endtask

  initial begin : main
    int d0, done_cyc, seq_err;
    bit ok;
    logic [3:0] ren;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_enable = '0; avg_log2 = '0;
    for (int i = 0; i < NUM_CH; i++) exp_res[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_convert", 64'(adc_convert), 64'(0));
    check_eq("rst_sel", 64'(adc_sel), 64'(0));
    check_eq("rst_result", 64'(result), 64'(0));
    check_eq("rst_valid", 64'(result_valid), 64'(0));
    check_eq("rst_busy_done_to", 64'({busy, done, timeout_err}), 64'(0));
    reset = 1'b0;
    tick();

    // Basic sweep with start->convert latency.
    ch_enable = 4'b1011; avg_log2 = '0; resp_mode = 0; resp_delay = 5;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    check_eq("lat_t1_convert", 64'(adc_convert), 64'(0));
    check_eq("lat_t1_busy", 64'(busy), 64'(1));
    tick();
    check_eq("lat_t2_convert", 64'(adc_convert), 64'(1));
    wait_done(2000, ok);
    check_eq("basic_done_seen", 64'(ok), 64'(1));
    tick();
    check_eq("basic_done_cnt", 64'(done_cnt - d0), 64'(1));
    check_eq("basic_busy_end", 64'(busy), 64'(0));
    model_check("basic", 4'b1011, 0);
    check_eq("basic_literal", 64'(result), 64'(32'h13001110));

    // Averaging of four known samples: (10+11+12+14)>>2 = 11.
    pre_q = '{10, 11, 12, 14};
    do_sweep("avg4", 4'b0001, 2, 1, 3);
    check_eq("avg4_literal", 64'(result[7:0]), 64'(11));

    // Largest exponent: eight conversions per channel.
    do_sweep("avgmax", 4'b0101, 3, 2, 0);

    // Randomized sweeps.
    for (int it = 0; it < 6; it++) begin
      ren = 4'($urandom_range(1, 15));
      do_sweep($sformatf("rnd%0d", it), ren, int'($urandom_range(0, 3)), 2, 0);
    end

    // Timeout on channel 2.
    drop_en = 1'b1; drop_ch = 2;
    ch_enable = 4'b0111; avg_log2 = '0; resp_mode = 0; resp_delay = 3;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    wait_done(600, ok);
    done_cyc = cyc;
    check_eq("to_done_seen", 64'(ok), 64'(1));
    check_eq("to_err", 64'(timeout_err), 64'(1));
    check_eq("to_gap", 64'(done_cyc - last_conv_cyc), 64'(TIMEOUT_CYC));
    check_eq("to_valid", 64'(result_valid), 64'(4'b0011));
    check_eq("to_busy", 64'(busy), 64'(0));
    exp_res[0] = 8'h10;
    exp_res[1] = 8'h11;
    check_eq("to_result", 64'(result), 64'(pack_exp()));
    tick();
    check_eq("to_done_cnt", 64'(done_cnt - d0), 64'(1));
    check_eq("to_nconv", 64'(conv_q.size()), 64'(3));
    drop_en = 1'b0;
    cnt_down = 0;

    // Next accepted start clears the sticky error.
    ch_enable = 4'b0001;
    clear_logs();
    pulse_start();
    check_eq("to_clear", 64'(timeout_err), 64'(0));
    wait_done(2000, ok);
    check_eq("after_to_done_seen", 64'(ok), 64'(1));
    tick();
    model_check("after_to", 4'b0001, 0);

    // Continuous sweeps, ignored start while busy, stop after dropping continuous.
    ch_enable = 4'b0011; avg_log2 = '0; resp_mode = 0; resp_delay = 2; continuous = 1'b1;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    for (int s = 0; s < 2; s++) begin
      wait_done(500, ok);
      check_eq($sformatf("cont%0d_done_seen", s), 64'(ok), 64'(1));
      check_eq($sformatf("cont%0d_busy", s), 64'(busy), 64'(1));
      tick();
    end
    pulse_start();
    tick();
    continuous = 1'b0;
    wait_done(500, ok);
    check_eq("cont_last_done_seen", 64'(ok), 64'(1));
    tick();
    check_eq("cont_busy_end", 64'(busy), 64'(0));
    check_eq("cont_done_cnt", 64'(done_cnt - d0), 64'(3));
    check_eq("cont_nconv", 64'(conv_q.size()), 64'(6));
    seq_err = 0;
    for (int i = 0; i < conv_q.size(); i++) if (conv_q[i] != (i % 2)) seq_err++;
    check_eq("cont_seq", 64'(seq_err), 64'(0));
    exp_res[0] = 8'h10;
    exp_res[1] = 8'h11;
    check_eq("cont_result", 64'(result), 64'(pack_exp()));

    // Empty enable mask: done next cycle, no conversion.
    ch_enable = 4'b0000;
    clear_logs();
    d0 = done_cnt;
    pulse_start();
    check_eq("empty_done", 64'(done), 64'(1));
    check_eq("empty_valid", 64'(result_valid), 64'(0));
    tick();
    tick();
    check_eq("empty_nconv", 64'(conv_q.size()), 64'(0));
    check_eq("empty_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Spurious ready while idle.
    spur_req = 1'b1;
    repeat (3) tick();
    check_eq("spur_result", 64'(result), 64'(pack_exp()));
    check_eq("spur_valid_busy", 64'({result_valid, busy}), 64'(0));

    // Reset while waiting for the ADC; the late ready must be ignored.
    ch_enable = 4'b0100; avg_log2 = '0; resp_mode = 0; resp_delay = 6;
    clear_logs();
    pulse_start();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_res[i] = 8'h00;
    check_eq("mid_rst_sel", 64'(adc_sel), 64'(0));
    check_eq("mid_rst_outs", 64'({adc_convert, busy, done, timeout_err}), 64'(0));
    check_eq("mid_rst_result", 64'(result), 64'(pack_exp()));
    repeat (6) tick();
    check_eq("late_rdy_result", 64'(result), 64'(pack_exp()));
    check_eq("late_rdy_valid_busy", 64'({result_valid, busy}), 64'(0));
    check_eq("late_rdy_nconv", 64'(conv_q.size()), 64'(1));

    check_eq("pulse_width", 64'(viol), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
